// File: rtl/dmx6_pkg.sv
// Shared definitions for the six-way slot datapath: slot count, last slot
// index, slot index type and the select-code decode used by both the read-side
// muxes and the write-side distributor.
package dmx6_pkg;

  localparam int NSLOT = 6;
  localparam logic [2:0] LASTSLOT = 3'd5;

  typedef logic [2:0] slot_t;

  // sel_2=0 addresses slots 0..3 directly; sel_2=1 picks 4 or 5 from sel_0
  // only, so codes 6 and 7 alias onto slots 4 and 5.
  function automatic logic [NSLOT-1:0] slot_onehot(input slot_t sel);
    logic [NSLOT-1:0] oh;
    oh = '0;
    if (sel[2]) begin
      oh[4 + int'(sel[0])] = 1'b1;
    end else begin
      oh[sel[1:0]] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dmx6_dec.sv
// Combinational 3-bit slot index to 6-bit one-hot decoder with enable.
module dmx6_dec
  import dmx6_pkg::*;
(
  input  logic             en,
  input  slot_t            idx,
  output logic [NSLOT-1:0] oh
);

  // Decode only when enabled; a disabled decoder contributes no write strobe.
  always_comb begin
    oh = '0;
    if (en) begin
      oh = slot_onehot(idx);
    end
  end

endmodule

// File: rtl/dmx6_dist.sv
// Registered 1-to-6 distributor: explicit load at a decoded select code, or
// round-robin push through ptr with a one-cycle frame pulse after slot 5.
// Priority per edge is clr, then ld, then push. All outputs are registered.
module dmx6_dist
  import dmx6_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             sel_0,
  input  logic             sel_1,
  input  logic             sel_2,
  input  logic             ld,
  input  logic             push,
  input  logic             clr,
  output logic [WIDTH-1:0] q_0,
  output logic [WIDTH-1:0] q_1,
  output logic [WIDTH-1:0] q_2,
  output logic [WIDTH-1:0] q_3,
  output logic [WIDTH-1:0] q_4,
  output logic [WIDTH-1:0] q_5,
  output logic [NSLOT-1:0] vld,
  output slot_t            ptr,
  output logic             frame
);

  logic [WIDTH-1:0] q_r [NSLOT];
  logic             ld_en;
  logic             push_en;
  logic [NSLOT-1:0] ld_oh;
  logic [NSLOT-1:0] push_oh;
  logic [NSLOT-1:0] wr_oh;
  logic             at_last;

  // clr masks both write paths; ld masks push so at most one strobe is active.
  always_comb begin
    ld_en   = ~clr & ld;
    push_en = ~clr & ~ld & push;
    wr_oh   = ld_oh | push_oh;
    at_last = (ptr == LASTSLOT);
  end

  dmx6_dec u_dec_ld (
    .en  (ld_en),
    .idx ({sel_2, sel_1, sel_0}),
    .oh  (ld_oh)
  );

  dmx6_dec u_dec_push (
    .en  (push_en),
    .idx (ptr),
    .oh  (push_oh)
  );

  // Holding registers take d on their strobe; clr leaves them untouched.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        q_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (wr_oh[i]) begin
          q_r[i] <= d;
        end
      end
    end
  end

  // Valid flags, round-robin pointer (wraps at LASTSLOT) and frame pulse.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      vld   <= '0;
      ptr   <= '0;
      frame <= 1'b0;
    end else if (clr) begin
      vld   <= '0;
      ptr   <= '0;
      frame <= 1'b0;
    end else begin
      vld   <= vld | wr_oh;
      frame <= push_en & at_last;
      if (push_en) begin
        ptr <= at_last ? 3'd0 : ptr + 3'd1;
      end
    end
  end

  assign q_0 = q_r[0];
  assign q_1 = q_r[1];
  assign q_2 = q_r[2];
  assign q_3 = q_r[3];
  assign q_4 = q_r[4];
  assign q_5 = q_r[5];

endmodule
